vga_timing_gen: RTL and testbench

//  Upstream raster/timing stage for the image pipeline. Divides the system clock into a

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/pix_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants used by the timing stage, the
// image generator and the VGA output driver.
package vga_timing_pkg;

  localparam int COORD_W  = 11;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/pix_delay_line.sv
// Enable-gated shift register. Each stage resets to RST_VAL and advances only
// when en is high. DEPTH=0 is a plain wire from din to dout.
module pix_delay_line #(
  parameter int                WIDTH   = 3,
  parameter int                DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stg [DEPTH];

    // Shift one stage per enable; reset loads every stage with RST_VAL.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
      end else if (en) begin
        stg[0] <= din;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign dout = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing stage: pixel-rate enable, x/y counters, line/frame markers and
// sync/active flags delayed to line up with the colour pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 2,
  parameter int   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP       = vga_timing_pkg::H_FP,
  parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int   H_BP       = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP       = vga_timing_pkg::V_FP,
  parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int   V_BP       = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               active,
  output logic               h_sync,
  output logic               v_sync
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             act0;
  logic             hs_on;
  logic             vs_on;
  logic [2:0]       flags0;
  logic [2:0]       flags_d;

  // Clock divider; pix_en is registered so it reaches CLK_DIV clocks after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Raster counters advance once per pixel slot and wrap at the line/frame totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (x == H_LAST) begin
        x <= '0;
        y <= (y == V_LAST) ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

  // Markers flag the slot in which the line/frame origin is being presented.
  assign line_start  = pix_en && (x == '0);
  assign frame_start = pix_en && (x == '0) && (y == '0);

  // Undelayed flags, with sync converted to output level before the delay line
  // so the reset value of each stage is simply the deasserted level.
  assign act0   = (x < H_ACT_END) && (y < V_ACT_END);
  assign hs_on  = (x >= HS_BEGIN) && (x < HS_END);
  assign vs_on  = (y >= VS_BEGIN) && (y < VS_END);
  assign flags0 = {act0, hs_on ? SYNC_POL : ~SYNC_POL, vs_on ? SYNC_POL : ~SYNC_POL};

  pix_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (flags0),
    .dout (flags_d)
  );

  assign active = flags_d[2];
  assign h_sync = flags_d[1];
  assign v_sync = flags_d[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances share clk/rst:
//   a: default timing, CLK_DIV=2, PIPE_DELAY=2
//   z: default timing, CLK_DIV=2, PIPE_DELAY=0
//   s: tiny 16x12 raster, CLK_DIV=1, PIPE_DELAY=0, active-high syncs
module tb_vga_timing_gen;

  logic clk;
  logic rst;

  logic        a_pix_en, a_line_start, a_frame_start, a_active, a_h_sync, a_v_sync;
  logic [10:0] a_x, a_y;
  logic        z_pix_en, z_line_start, z_frame_start, z_active, z_h_sync, z_v_sync;
  logic [10:0] z_x, z_y;
  logic        s_pix_en, s_line_start, s_frame_start, s_active, s_h_sync, s_v_sync;
  logic [10:0] s_x, s_y;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(a_pix_en), .x(a_x), .y(a_y),
    .line_start(a_line_start), .frame_start(a_frame_start),
    .active(a_active), .h_sync(a_h_sync), .v_sync(a_v_sync)
  );

  vga_timing_gen #(.PIPE_DELAY(0)) dut_z (
    .clk(clk), .rst(rst), .pix_en(z_pix_en), .x(z_x), .y(z_y),
    .line_start(z_line_start), .frame_start(z_frame_start),
    .active(z_active), .h_sync(z_h_sync), .v_sync(z_v_sync)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(s_pix_en), .x(s_x), .y(s_y),
    .line_start(s_line_start), .frame_start(s_frame_start),
    .active(s_active), .h_sync(s_h_sync), .v_sync(s_v_sync)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks: advance to the next sampling point / next pixel slot of dut_a.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic next_pix();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_pix_en && n < 8);
    if (!a_pix_en) check("pix_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int guard;
    logic prev_act, prev_hs;
    int z_hlow_cnt, z_hlow_first, z_hlow_last, z_act_cnt, z_act_last;
    int s_fs_cnt, s_vs_cnt, s_hs_cnt, s_pe_low, s_vs_ymin, s_vs_ymax, s_over;
    logic [10:0] psx, psy;

    // 1: reset values and divider start-up
    rst = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_pix_en", a_pix_en, 0);
    check("rst_line_start", a_line_start, 0);
    check("rst_frame_start", a_frame_start, 0);
    check("rst_active", a_active, 0);
    check("rst_h_sync", a_h_sync, 1);
    check("rst_v_sync", a_v_sync, 1);
    check("rst_z_h_sync", z_h_sync, 1);
    check("rst_s_h_sync", s_h_sync, 0);
    check("rst_s_pix_en", s_pix_en, 0);
    rst = 1'b0;

    tick();
    check("pe_clk1", a_pix_en, 0);
    check("s_pe_clk1", s_pix_en, 1);
    tick();
    check("pe_clk2", a_pix_en, 1);
    check("first_x", a_x, 0);
    check("first_line_start", a_line_start, 1);
    check("first_frame_start", a_frame_start, 1);
    tick();
    check("pe_clk3", a_pix_en, 0);
    check("x_after_first", a_x, 1);
    check("ls_low_no_pe", a_line_start, 0);
    tick();
    check("pe_clk4", a_pix_en, 1);
    check("x_hold", a_x, 1);

    // 3 and 5: scan line 0 (x=1..798) on both delay settings
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd642);
    exp_q.push_back(32'd658);
    prev_act = 1'b0; prev_hs = 1'b1;
    z_hlow_cnt = 0; z_hlow_first = -1; z_hlow_last = -1; z_act_cnt = 0; z_act_last = -1;
    guard = 0;
    while (!(a_x == 11'd799 && a_y == 11'd0) && guard < 1000) begin
      if (!z_h_sync) begin
        z_hlow_cnt++;
        if (z_hlow_first < 0) z_hlow_first = int'(z_x);
        z_hlow_last = int'(z_x);
      end
      if (z_active) begin
        z_act_cnt++;
        z_act_last = int'(z_x);
      end
      if ((!prev_act && a_active) || (prev_act && !a_active) || (prev_hs && !a_h_sync)) begin
        if (exp_q.size() == 0) check("a_extra_edge", {21'd0, a_x}, 32'hFFFF);
        else check("a_edge_x", {21'd0, a_x}, exp_q.pop_front());
      end
      if (!prev_hs && a_h_sync) check("a_hs_rise_x", a_x, 754);
      prev_act = a_active;
      prev_hs  = a_h_sync;
      guard++;
      next_pix();
    end
    check("a_edges_seen", exp_q.size(), 0);
    check("z_hlow_cnt", z_hlow_cnt, 96);
    check("z_hlow_first", z_hlow_first, 656);
    check("z_hlow_last", z_hlow_last, 751);
    check("z_act_cnt", z_act_cnt, 639);
    check("z_act_last", z_act_last, 639);

    // 2: end-of-line wrap
    check("reach_x799", a_x, 799);
    next_pix();
    check("wrap_x", a_x, 0);
    check("wrap_y", a_y, 1);
    check("wrap_line_start", a_line_start, 1);
    check("wrap_frame_start", a_frame_start, 0);

    // 6: mid-frame reset at (300,1)
    guard = 0;
    while (!(a_x == 11'd300 && a_y == 11'd1) && guard < 1200) begin
      guard++;
      next_pix();
    end
    check("reach_x300", a_x, 300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_x", a_x, 0);
    check("mid_rst_y", a_y, 0);
    check("mid_rst_pix_en", a_pix_en, 0);
    check("mid_rst_active", a_active, 0);
    check("mid_rst_h_sync", a_h_sync, 1);
    check("mid_rst_v_sync", a_v_sync, 1);

    // 4: three full frames of the small raster, with dut_a restart checks inline
    s_fs_cnt = 0; s_vs_cnt = 0; s_hs_cnt = 0; s_pe_low = 0; s_over = 0;
    s_vs_ymin = 99; s_vs_ymax = -1;
    psx = '0; psy = '0;
    for (int i = 0; i < 576; i++) begin
      tick();
      if (i == 0) check("restart_pe_clk1", a_pix_en, 0);
      if (i == 1) begin
        check("restart_pe_clk2", a_pix_en, 1);
        check("restart_frame_start", a_frame_start, 1);
      end
      if (i == 0) begin
        check("s_first_x", s_x, 0);
        check("s_first_frame_start", s_frame_start, 1);
      end
      if (psx == 11'd15 && psy == 11'd11) begin
        check("s_wrap_x", s_x, 0);
        check("s_wrap_y", s_y, 0);
        check("s_wrap_frame_start", s_frame_start, 1);
      end
      if (!s_pix_en) s_pe_low++;
      if (s_frame_start) s_fs_cnt++;
      if (s_h_sync) s_hs_cnt++;
      if (s_v_sync) begin
        s_vs_cnt++;
        if (int'(s_y) < s_vs_ymin) s_vs_ymin = int'(s_y);
        if (int'(s_y) > s_vs_ymax) s_vs_ymax = int'(s_y);
      end
      if (s_x > 11'd15 || s_y > 11'd11) s_over++;
      psx = s_x;
      psy = s_y;
    end
    check("s_pe_low", s_pe_low, 0);
    check("s_frame_starts", s_fs_cnt, 3);
    check("s_hs_cnt", s_hs_cnt, 108);
    check("s_vs_cnt", s_vs_cnt, 96);
    check("s_vs_ymin", s_vs_ymin, 8);
    check("s_vs_ymax", s_vs_ymax, 9);
    check("s_over_range", s_over, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
